// File: rtl/spi_engine.sv
// SPI master engine, mode 0 (SCK idles low), one byte per START, MSB first.
// Each phase (lead-in, SCK high, SCK low, trail-out) lasts CLKDIV+1 clocks.
// A transfer is 1 lead + 8 high + 7 low + 1 trail = 17 phases.
module spi_engine #(
  parameter int DIVW = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            START,
  input  logic [7:0]      DIN,
  input  logic [DIVW-1:0] CLKDIV,
  input  logic            SSEL,
  input  logic            KEEP,
  input  logic            RELEASE,
  output logic [7:0]      DOUT,
  output logic            BUSY,
  output logic            DONE,
  output logic            SCK,
  output logic            MOSI,
  input  logic            MISO,
  output logic [1:0]      nSS
);

  typedef enum logic [2:0] {IDLE, LEAD, SCKHI, SCKLO, TRAIL} state_t;

  state_t          state;
  logic [DIVW-1:0] cnt;     // phase down-counter, reloaded on every state entry
  logic [DIVW-1:0] div;     // divider latched at acceptance
  logic            keep;    // keep-select flag latched at acceptance
  logic [7:0]      shreg;   // tx bits shift out of [7], rx bits shift into [0]
  logic [2:0]      bitcnt;  // completed SCK pulses

  // Control FSM with all outputs registered.
  // The shift happens on the SCK rising edge together with the MISO sample,
  // so shreg[7] already holds the next tx bit when MOSI is updated on the
  // falling edge; this keeps DIN[0] from being overwritten by the first
  // received bit.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      cnt    <= '0;
      div    <= '0;
      keep   <= 1'b0;
      shreg  <= 8'h00;
      bitcnt <= 3'd0;
      DOUT   <= 8'h00;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      SCK    <= 1'b0;
      MOSI   <= 1'b0;
      nSS    <= 2'b11;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            shreg <= DIN;
            MOSI  <= DIN[7];
            nSS   <= SSEL ? 2'b01 : 2'b10;
            BUSY  <= 1'b1;
            div   <= CLKDIV;
            keep  <= KEEP;
            cnt   <= CLKDIV;
            SCK   <= 1'b0;
            state <= LEAD;
          end else if (RELEASE) begin
            nSS <= 2'b11;
          end
        end
        LEAD, SCKLO: begin
          if (cnt == '0) begin
            SCK   <= 1'b1;
            shreg <= {shreg[6:0], MISO};
            cnt   <= div;
            state <= SCKHI;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        SCKHI: begin
          if (cnt == '0) begin
            SCK    <= 1'b0;
            bitcnt <= bitcnt + 3'd1;
            cnt    <= div;
            if (bitcnt != 3'd7) begin
              MOSI  <= shreg[7];
              state <= SCKLO;
            end else begin
              state <= TRAIL;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        TRAIL: begin
          if (cnt == '0) begin
            DOUT  <= shreg;
            DONE  <= 1'b1;
            BUSY  <= 1'b0;
            state <= IDLE;
            if (!keep) nSS <= 2'b11;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_engine.sv
// Directed bench for spi_engine: expected bytes go into a queue at START and
// are popped and compared when DONE is seen; a monitor gathers SCK/MOSI/nSS
// statistics per transfer.
module tb_spi_engine;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       START = 1'b0;
  logic [7:0] DIN = 8'h00;
  logic [3:0] CLKDIV = 4'd0;
  logic       SSEL = 1'b0;
  logic       KEEP = 1'b0;
  logic       RELEASE = 1'b0;
  logic [7:0] DOUT;
  logic       BUSY, DONE, SCK, MOSI, MISO;
  logic [1:0] nSS;

  logic       loop = 1'b1;
  logic       miso_val = 1'b0;
  assign MISO = loop ? MOSI : miso_val;

  int total = 0;
  int bad = 0;
  logic [7:0] expq[$];

  spi_engine #(.DIVW(4)) dut (
    .CLK(CLK), .RST(RST), .START(START), .DIN(DIN), .CLKDIV(CLKDIV),
    .SSEL(SSEL), .KEEP(KEEP), .RELEASE(RELEASE), .DOUT(DOUT), .BUSY(BUSY),
    .DONE(DONE), .SCK(SCK), .MOSI(MOSI), .MISO(MISO), .nSS(nSS)
  );

  always #5 CLK = ~CLK;

  // free-running edge counter
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // per-transfer statistics, restarted whenever BUSY rises
  int   t0 = 0, rises = 0, hi_run = 0, hi_min = 0, hi_max = 0, mosi_hi = 0;
  int   done_cnt = 0, ss1_hi = 0;
  logic pbusy = 1'b0, psck = 1'b0, both_low = 1'b0;
  always @(negedge CLK) begin
    pbusy <= BUSY;
    psck  <= SCK;
    if (DONE) done_cnt <= done_cnt + 1;
    if (nSS[1]) ss1_hi <= ss1_hi + 1;
    if (nSS == 2'b00) both_low <= 1'b1;
    if (BUSY && MOSI) mosi_hi <= mosi_hi + 1;
    if (SCK && !psck) rises <= rises + 1;
    if (SCK) hi_run <= hi_run + 1;
    else if (psck) begin
      hi_run <= 0;
      if (hi_run < hi_min) hi_min <= hi_run;
      if (hi_run > hi_max) hi_max <= hi_run;
    end
    if (BUSY && !pbusy) begin
      t0 <= cyc; rises <= 0; hi_run <= 0; hi_min <= 255; hi_max <= 0;
      mosi_hi <= (MOSI ? 1 : 0);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // drive START mid-cycle; it is accepted at the next rising edge
  task automatic start_xfer(input logic [7:0] d, input logic [3:0] dv,
                            input logic s, input logic k);
    DIN = d; CLKDIV = dv; SSEL = s; KEEP = k; START = 1'b1;
    expq.push_back(loop ? d : (miso_val ? 8'hFF : 8'h00));
    @(posedge CLK); #1;
    START = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int lat);
    logic [7:0] e;
    bit got = 0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge CLK); #1;
      if (DONE) begin
        got = 1;
        e = expq.pop_front();
        chk({tag, "_dout"}, DOUT, e);
        chk({tag, "_lat"}, cyc - t0, lat);
      end
    end
    if (!got) chk({tag, "_timeout"}, 0, 1);
  endtask

  int snap;

  initial begin
    // reset state, forced without any clock edge
    #1 RST = 1'b1;
    #1;
    chk("rst_sck", SCK, 0);
    chk("rst_mosi", MOSI, 0);
    chk("rst_nss", nSS, 2'b11);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_dout", DOUT, 8'h00);
    @(negedge CLK) RST = 1'b0;
    @(negedge CLK);

    // loopback A5, CLKDIV=0, device 0
    loop = 1'b1;
    start_xfer(8'hA5, 4'd0, 1'b0, 1'b0);
    chk("a5_busy", BUSY, 1);
    chk("a5_nss", nSS, 2'b10);
    chk("a5_mosi", MOSI, 1);
    chk("a5_sck", SCK, 0);
    wait_done("a5", 17);
    chk("a5_rises", rises, 8);
    @(negedge CLK); #1;
    chk("a5_nss_after", nSS, 2'b11);
    chk("a5_busy_after", BUSY, 0);

    // MISO tied high, DIN=00, CLKDIV=3
    loop = 1'b0; miso_val = 1'b1;
    start_xfer(8'h00, 4'd3, 1'b0, 1'b0);
    wait_done("ff", 68);
    chk("ff_rises", rises, 8);
    chk("ff_hi_min", hi_min, 4);
    chk("ff_hi_max", hi_max, 4);
    chk("ff_mosi_hi", mosi_hi, 0);

    // START during BUSY ignored, and input changes have no effect
    loop = 1'b1;
    @(negedge CLK); #1;
    snap = done_cnt;
    start_xfer(8'h81, 4'd0, 1'b0, 1'b0);
    repeat (4) @(negedge CLK);
    DIN = 8'h3C; CLKDIV = 4'd3; SSEL = 1'b1; KEEP = 1'b1; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    chk("ign_nss", nSS, 2'b10);
    chk("ign_busy", BUSY, 1);
    wait_done("ign", 17);
    repeat (20) @(negedge CLK);
    #1;
    chk("ign_done_once", done_cnt - snap, 1);
    chk("ign_nss_after", nSS, 2'b11);
    KEEP = 1'b0;

    // kept select on device 1 across two back-to-back bytes, then RELEASE
    start_xfer(8'h12, 4'd0, 1'b1, 1'b1);
    snap = ss1_hi;
    wait_done("k12", 17);
    start_xfer(8'h34, 4'd1, 1'b1, 1'b1);
    wait_done("k34", 34);
    chk("keep_nss", nSS, 2'b01);
    chk("keep_ss1_low", ss1_hi - snap, 0);
    RELEASE = 1'b1;
    @(posedge CLK); #1;
    RELEASE = 1'b0;
    chk("release_nss", nSS, 2'b11);

    // select switch while kept; START beats RELEASE; RELEASE ignored when busy
    start_xfer(8'h0F, 4'd0, 1'b1, 1'b1);
    wait_done("k0f", 17);
    chk("sw_before", nSS, 2'b01);
    RELEASE = 1'b1;
    start_xfer(8'hF0, 4'd0, 1'b0, 1'b0);
    chk("sw_after", nSS, 2'b10);
    @(posedge CLK); #1;
    chk("rel_busy_nss", nSS, 2'b10);
    RELEASE = 1'b0;
    wait_done("sw", 17);
    chk("sw_end_nss", nSS, 2'b11);

    // reset mid-transfer at cycle 9
    start_xfer(8'hC3, 4'd0, 1'b0, 1'b0);
    snap = done_cnt;
    repeat (8) @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("abort_sck", SCK, 0);
    chk("abort_nss", nSS, 2'b11);
    chk("abort_busy", BUSY, 0);
    void'(expq.pop_back());
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    repeat (20) @(negedge CLK);
    #1;
    chk("abort_no_done", done_cnt - snap, 0);
    start_xfer(8'h5A, 4'd0, 1'b0, 1'b0);
    wait_done("5a", 17);

    chk("never_both_low", both_low, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
